// File: rtl/bus_b2a_receiver_pkg.sv
// Shared types and constants for the B-to-A receive path of the bus transceiver.
package bus_b2a_receiver_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_TURN = 2'd1,
    ST_RX   = 2'd2,
    ST_TX   = 2'd3
  } mode_state_e;

  localparam logic DIR_B2A = 1'b0;

endpackage

// File: rtl/bus_b2a_receiver_sync_fifo_ctl.sv
// Small synchronous FIFO with occupancy counter and a registered head-of-queue output.
module sync_fifo_ctl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [WIDTH-1:0] r_rdata;
  logic             r_valid;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [AW-1:0]    w_wr_next;
  logic [AW-1:0]    w_rd_next;
  logic [AW:0]      w_level_next;
  logic [WIDTH-1:0] w_head_next;

  // Handshake qualification, next pointers/level and next head value.
  always_comb begin
    w_empty      = (r_level == '0);
    w_full       = (r_level == FULL_LVL);
    w_pop        = pop & ~w_empty & ~flush;
    w_push       = push & (~w_full | w_pop) & ~flush;
    w_wr_next    = r_wr_ptr;
    w_rd_next    = r_rd_ptr;
    w_level_next = r_level;
    w_head_next  = r_rdata;
    if (flush) begin
      w_wr_next    = '0;
      w_rd_next    = '0;
      w_level_next = '0;
    end else begin
      if (w_push) begin
        w_wr_next = r_wr_ptr + AW'(1);
      end else begin
        w_wr_next = r_wr_ptr;
      end
      if (w_pop) begin
        w_rd_next = r_rd_ptr + AW'(1);
      end else begin
        w_rd_next = r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   w_level_next = r_level + (AW+1)'(1);
        2'b01:   w_level_next = r_level - (AW+1)'(1);
        default: w_level_next = r_level;
      endcase
      // The written slot becomes the head only when the queue would otherwise be empty.
      if (w_level_next == '0) begin
        w_head_next = r_rdata;
      end else if (w_push && (r_wr_ptr == w_rd_next)) begin
        w_head_next = wdata;
      end else begin
        w_head_next = r_mem[w_rd_next];
      end
    end
  end

  // Storage array write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy and registered head output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_rdata  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_level  <= w_level_next;
      r_rdata  <= w_head_next;
      r_valid  <= (w_level_next != '0);
    end
  end

  assign rdata = r_rdata;
  assign valid = r_valid;
  assign full  = w_full;
  assign level = r_level;

endmodule

// File: rtl/bus_b2a_receiver.sv
// B-to-A receive path: mode FSM gates bus capture into a FIFO drained by a valid/ready consumer.
module bus_b2a_receiver
  import bus_b2a_receiver_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    sysclk,
  input  logic                    sys_rst_n,
  input  logic                    G_n,
  input  logic                    DIR,
  input  logic [WIDTH-1:0]        B_in,
  input  logic                    B_strobe,
  output logic [WIDTH-1:0]        A_out,
  output logic                    A_valid,
  input  logic                    A_ready,
  output logic                    A_oe,
  input  logic                    flush,
  output logic                    ovf,
  input  logic                    ovf_clr,
  output logic [$clog2(DEPTH):0]  level
);

  mode_state_e r_state;
  mode_state_e w_state_next;
  logic        r_a_oe;
  logic        r_ovf;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_ovf_set;

  // Mode state register.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Mode next-state; every entry into RX passes through the TURN settle cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_OFF: begin
        if (G_n) begin
          w_state_next = ST_OFF;
        end else if (DIR != DIR_B2A) begin
          w_state_next = ST_TX;
        end else begin
          w_state_next = ST_TURN;
        end
      end
      ST_TURN: begin
        if (G_n) begin
          w_state_next = ST_OFF;
        end else if (DIR != DIR_B2A) begin
          w_state_next = ST_TX;
        end else begin
          w_state_next = ST_RX;
        end
      end
      ST_RX: begin
        if (G_n) begin
          w_state_next = ST_OFF;
        end else if (DIR != DIR_B2A) begin
          w_state_next = ST_TURN;
        end else begin
          w_state_next = ST_RX;
        end
      end
      ST_TX: begin
        if (G_n) begin
          w_state_next = ST_OFF;
        end else if (DIR == DIR_B2A) begin
          w_state_next = ST_TURN;
        end else begin
          w_state_next = ST_TX;
        end
      end
      default: w_state_next = ST_OFF;
    endcase
  end

  // Live pin gating keeps a strobe in the cycle G_n/DIR change out of the FIFO.
  always_comb begin
    w_push    = (r_state == ST_RX) & B_strobe & ~G_n & (DIR == DIR_B2A);
    w_pop     = A_valid & A_ready;
    w_ovf_set = w_push & w_full & ~w_pop & ~flush;
  end

  // Pad enable and sticky overflow flag.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_a_oe <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_a_oe <= (w_state_next == ST_RX);
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  sync_fifo_ctl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (sysclk),
    .rst_n (sys_rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (flush),
    .wdata (B_in),
    .rdata (A_out),
    .valid (A_valid),
    .full  (w_full),
    .level (level)
  );

  assign A_oe = r_a_oe;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_bus_b2a_receiver.sv
// Scoreboard bench for bus_b2a_receiver: a reference mode/queue model predicts every output.
module tb_bus_b2a_receiver;
  import bus_b2a_receiver_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             sysclk;
  logic             sys_rst_n;
  logic             G_n;
  logic             DIR;
  logic [WIDTH-1:0] B_in;
  logic             B_strobe;
  logic [WIDTH-1:0] A_out;
  logic             A_valid;
  logic             A_ready;
  logic             A_oe;
  logic             flush;
  logic             ovf;
  logic             ovf_clr;
  logic [LW-1:0]    level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q [$];
  mode_state_e      m_state;
  logic             m_ovf;

  bus_b2a_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .G_n       (G_n),
    .DIR       (DIR),
    .B_in      (B_in),
    .B_strobe  (B_strobe),
    .A_out     (A_out),
    .A_valid   (A_valid),
    .A_ready   (A_ready),
    .A_oe      (A_oe),
    .flush     (flush),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .level     (level)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_state = ST_OFF;
    m_ovf   = 1'b0;
  endtask

  // One clock: predict from current inputs, clock, then compare all outputs.
  task automatic step();
    bit          pop_m;
    bit          push_m;
    bit          acc;
    mode_state_e nxt;
    logic [WIDTH-1:0] popped;
    pop_m  = (exp_q.size() != 0) && A_ready;
    push_m = (m_state == ST_RX) && B_strobe && !G_n && !DIR;
    if (pop_m) chk("pop_data", A_out, exp_q[0]);
    if (flush) begin
      exp_q.delete();
    end else begin
      acc = push_m && ((exp_q.size() < DEPTH) || pop_m);
      if (pop_m) popped = exp_q.pop_front();
      if (acc) exp_q.push_back(B_in);
      if (push_m && !acc) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
    if (flush && ovf_clr) m_ovf = 1'b0;
    nxt = m_state;
    case (m_state)
      ST_OFF:  nxt = G_n ? ST_OFF : (DIR ? ST_TX : ST_TURN);
      ST_TURN: nxt = G_n ? ST_OFF : (DIR ? ST_TX : ST_RX);
      ST_RX:   nxt = G_n ? ST_OFF : (DIR ? ST_TURN : ST_RX);
      ST_TX:   nxt = G_n ? ST_OFF : (DIR ? ST_TX : ST_TURN);
      default: nxt = ST_OFF;
    endcase
    m_state = nxt;
    @(posedge sysclk);
    #1;
    chk("level", level, exp_q.size());
    chk("a_valid", A_valid, exp_q.size() != 0);
    chk("a_oe", A_oe, m_state == ST_RX);
    chk("ovf", ovf, m_ovf);
    if (exp_q.size() != 0) chk("a_out_head", A_out, exp_q[0]);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    G_n = 1'b1; DIR = 1'b0; B_in = 8'h00; B_strobe = 1'b0;
    A_ready = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
    model_reset();
    #2;
    chk("rst_a_out", A_out, 32'h0);
    chk("rst_a_valid", A_valid, 32'h0);
    chk("rst_a_oe", A_oe, 32'h0);
    chk("rst_ovf", ovf, 32'h0);
    chk("rst_level", level, 32'h0);
    #10 sys_rst_n = 1'b1;

    // Enable B-to-A: OFF -> TURN -> RX, strobe in TURN ignored.
    G_n = 1'b0; DIR = 1'b0;
    step();
    B_strobe = 1'b1; B_in = 8'h5A;
    step();

    // Three bytes queued, then drained in order.
    B_in = 8'hA1; step();
    B_in = 8'hB2; step();
    B_in = 8'hC3; step();
    B_strobe = 1'b0; A_ready = 1'b1;
    repeat (3) step();
    A_ready = 1'b0;

    // Fill, overflow, then full with simultaneous pop.
    B_strobe = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      B_in = WIDTH'(i);
      step();
    end
    B_in = 8'h05; step();
    A_ready = 1'b1; B_in = 8'h06; step();
    B_strobe = 1'b0;
    repeat (4) step();
    A_ready = 1'b0; ovf_clr = 1'b1; step();
    ovf_clr = 1'b0;

    // Direction change during a strobe, then drain while in TX.
    B_strobe = 1'b1;
    B_in = 8'h11; step();
    B_in = 8'h22; step();
    DIR = 1'b1; B_in = 8'h77; step();
    B_strobe = 1'b0; step();
    A_ready = 1'b1; repeat (2) step();
    A_ready = 1'b0; DIR = 1'b0;
    step(); step();

    // Flush beats a coincident strobe.
    B_strobe = 1'b1;
    B_in = 8'h31; step();
    B_in = 8'h32; step();
    flush = 1'b1; B_in = 8'h99; step();
    flush = 1'b0; B_strobe = 1'b0; step();

    // Overflow wins over a coincident ovf_clr.
    B_strobe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      B_in = WIDTH'(8'hE1 + i);
      step();
    end
    B_in = 8'hE5; ovf_clr = 1'b1; step();
    B_strobe = 1'b0; step();
    ovf_clr = 1'b0; flush = 1'b1; step();
    flush = 1'b0;

    // Randomised traffic across all modes.
    for (int i = 0; i < 120; i++) begin
      G_n      = ($urandom_range(0, 15) == 0);
      DIR      = ($urandom_range(0, 9) == 0);
      B_strobe = $urandom_range(0, 1);
      B_in     = WIDTH'($urandom);
      A_ready  = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 40) == 0);
      ovf_clr  = ($urandom_range(0, 10) == 0);
      step();
    end
    G_n = 1'b0; DIR = 1'b0; B_strobe = 1'b0; A_ready = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
    flush = 1'b1; step();
    flush = 1'b0; step(); step(); step();

    // Asynchronous reset in the middle of a burst.
    B_strobe = 1'b1;
    B_in = 8'h41; step();
    B_in = 8'h42; step();
    B_in = 8'h43; step();
    chk("pre_rst_level", level, 32'd3);
    B_in = 8'h44;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_a_valid", A_valid, 32'h0);
    chk("async_a_oe", A_oe, 32'h0);
    chk("async_level", level, 32'h0);
    chk("async_a_out", A_out, 32'h0);
    model_reset();
    G_n = 1'b1; B_strobe = 1'b0;
    #2 sys_rst_n = 1'b1;
    step();
    G_n = 1'b0; DIR = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
